byte_serial_adder: RTL and testbench

Multi-byte adder that performs an 8·BYTES-bit addition one byte per cycle, LSB first, through a single `ripple_adder_8bit` instance. It sits directly upstream of the 8-bit adder: it registers wide operands, feeds byte slices and the chained carry into the adder, and collects sum bytes and the final carry-out. Operands enter and results leave through valid/ready handshakes.

---
 rtl/adder_pkg.sv | 11 +
 rtl/ripple_adder_8bit.sv | 22 ++
 rtl/byte_serial_adder.sv | 103 ++++++++++
 tb/tb_byte_serial_adder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants for the byte-serial adder slice:
// FSM state encoding and the per-step byte width.
package adder_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int BYTE_W = 8;

endpackage

// File: rtl/ripple_adder_8bit.sv
// Purely combinational 8-bit adder with carry in/out.
// Used once per cycle by the byte-serial wrapper.
module ripple_adder_8bit
    import adder_pkg::*;
(
    input  logic [BYTE_W-1:0] i_a,
    input  logic [BYTE_W-1:0] i_b,
    input  logic              i_cin,
    output logic [BYTE_W-1:0] o_sum,
    output logic              o_cout
);

    logic [BYTE_W:0] full;

    // Nine-bit add so the carry falls out as the top bit
    always_comb begin
        full   = {1'b0, i_a} + {1'b0, i_b} + {{BYTE_W{1'b0}}, i_cin};
        o_sum  = full[BYTE_W-1:0];
        o_cout = full[BYTE_W];
    end

endmodule

// File: rtl/byte_serial_adder.sv
// Wide adder that walks the operands one byte per cycle,
// LSB first, through a single 8-bit adder.
module byte_serial_adder
    import adder_pkg::*;
#(
    parameter int BYTES = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [8*BYTES-1:0]    i_a,
    input  logic [8*BYTES-1:0]    i_b,
    input  logic                  i_cin,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [8*BYTES-1:0]    o_sum,
    output logic                  o_cout
);

    localparam int W  = 8 * BYTES;
    localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;

    logic [BYTE_W-1:0] add_sum;
    logic              add_cout;
    logic [W-1:0]      ins;

    ripple_adder_8bit u_add (
        .i_a    (a_q[BYTE_W-1:0]),
        .i_b    (b_q[BYTE_W-1:0]),
        .i_cin  (carry_q),
        .o_sum  (add_sum),
        .o_cout (add_cout)
    );

    // Next-state: accept in IDLE, shift one byte per ADD cycle, hold in DONE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ins     = '0;
        ins[W-1 -: BYTE_W] = add_sum;
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    a_d     = i_a;
                    b_d     = i_b;
                    carry_d = i_cin;
                    cnt_d   = '0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                sum_d   = (sum_q >> BYTE_W) | ins;
                carry_d = add_cout;
                a_d     = a_q >> BYTE_W;
                b_d     = b_q >> BYTE_W;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) state_d = S_DONE;
            end
            S_DONE: begin
                if (i_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers, all cleared by reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign o_ready = (state_q == S_IDLE);
    assign o_valid = (state_q == S_DONE);
    assign o_sum   = sum_q;
    assign o_cout  = carry_q;

endmodule

// File: tb/tb_byte_serial_adder.sv
// Scoreboard bench for byte_serial_adder (BYTES=4):
// directed corner cases plus a randomized soak.
module tb_byte_serial_adder;

    localparam int BYTES = 4;
    localparam int W = 8 * BYTES;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_valid = 1'b0;
    logic         o_ready;
    logic [W-1:0] i_a = '0;
    logic [W-1:0] i_b = '0;
    logic         i_cin = 1'b0;
    logic         o_valid;
    logic         i_ready = 1'b1;
    logic [W-1:0] o_sum;
    logic         o_cout;

    int errors = 0;
    int checks = 0;
    bit rand_en = 1'b0;
    logic [W:0] exp_q[$];

    byte_serial_adder #(.BYTES(BYTES)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_cin   (i_cin),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_sum   (o_sum),
        .o_cout  (o_cout)
    );

    initial forever #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [W:0] act,
                         input logic [W:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    // Monitor: a result transfers at the next edge when valid && ready
    always @(negedge i_clk) begin
        if (i_rst_n && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", {o_cout, o_sum}, '1);
            end else begin
                check("result", {o_cout, o_sum}, exp_q.pop_front());
            end
        end
    end

    // Random consumer backpressure during the soak
    always @(posedge i_clk) begin
        if (rand_en) begin
            #1 i_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c);
        int n;
        i_a = a;
        i_b = b;
        i_cin = c;
        i_valid = 1'b1;
        n = 0;
        @(negedge i_clk);
        while (!o_ready && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_ready) begin
            check("issue_timeout", 0, 1);
        end else begin
            exp_q.push_back(model(a, b, c));
        end
        @(posedge i_clk);
        #1 i_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !o_ready) && n < 100) begin
            @(posedge i_clk);
            #1 n++;
        end
        if (exp_q.size() != 0 || !o_ready) check("drain_timeout", 0, 1);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!o_valid && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_valid) check("valid_timeout", 0, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, {32'd0, o_ready}, 1);
        check({tag, "_valid"}, {32'd0, o_valid}, 0);
        check({tag, "_sum_cout"}, {o_cout, o_sum}, 0);
    endtask

    initial begin
        #2;
        check_reset_vals("reset");
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        @(posedge i_clk);
        #1 check_reset_vals("post_reset");

        // Cross-byte carry with exact latency
        issue(32'h0000_00FF, 32'h0000_0001, 1'b0);
        for (int k = 1; k <= BYTES; k++) begin
            @(posedge i_clk);
            #1 check($sformatf("latency_e%0d", k), {32'd0, o_valid},
                     (k == BYTES) ? 1 : 0);
        end
        drain();

        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        drain();
        issue(32'h1234_5678, 32'h8765_4321, 1'b1);
        drain();
        check("cin_model", model(32'h1234_5678, 32'h8765_4321, 1'b1),
              {1'b0, 32'h9999_999A});

        // Backpressure: hold DONE while new operands are offered
        i_ready = 1'b0;
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        wait_valid();
        i_a = 32'hCAFE_0001;
        i_b = 32'h0101_0101;
        i_cin = 1'b1;
        i_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge i_clk);
            #1;
            check("bp_valid", {32'd0, o_valid}, 1);
            check("bp_ready", {32'd0, o_ready}, 0);
            check("bp_sum", {o_cout, o_sum}, {1'b1, 32'h0});
        end
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        check("bp_idle_ready", {32'd0, o_ready}, 1);
        check("bp_idle_valid", {32'd0, o_valid}, 0);
        exp_q.push_back(model(32'hCAFE_0001, 32'h0101_0101, 1'b1));
        @(posedge i_clk);
        #1;
        check("bp_accepted", {32'd0, o_ready}, 0);
        i_valid = 1'b0;
        drain();

        // Asynchronous reset mid-cycle while holding a result
        i_ready = 1'b0;
        issue(32'h1234_5678, 32'h8765_4321, 1'b1);
        wait_valid();
        #2 i_rst_n = 1'b0;
        #1 check_reset_vals("async_rst");
        exp_q.delete();
        i_ready = 1'b1;
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;

        // Reset in the middle of ADD discards the operation
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        @(posedge i_clk);
        #2 i_rst_n = 1'b0;
        #1 check_reset_vals("mid_add_rst");
        exp_q.delete();
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge i_clk);
            #1 check("no_valid_after_rst", {32'd0, o_valid}, 0);
        end
        issue(32'h0001_0000, 32'h0001_0000, 1'b0);
        drain();
        check("after_rst_model", model(32'h0001_0000, 32'h0001_0000, 1'b0),
              {1'b0, 32'h0002_0000});

        // Randomized soak
        rand_en = 1'b1;
        for (int n = 0; n < 200; n++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) a = '1;
            if ($urandom_range(0, 7) == 0) b = W'($urandom_range(0, 2));
            repeat ($urandom_range(0, 2)) @(posedge i_clk);
            issue(a, b, 1'(($urandom_range(0, 1))));
        end
        rand_en = 1'b0;
        @(posedge i_clk);
        #2 i_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
